// File: rtl/sync_fifo_param_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_pkg : shared P2 buffer defaults and parameter helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sync_fifo_param_pkg;

  // Default word width and depth shared by the SA buffers and their benches
  localparam int P2_WIDTH   = 8;
  localparam int FIFO_DEPTH = 8;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem : DEPTH x WIDTH register array, synchronous write, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  // Storage is deliberately left out of reset so a macro can be dropped in
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param : single-clock FIFO with count, almost flags, sticky errors
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH    = P2_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_read,
  input  logic              en_write,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  data_out,
  output logic              is_full,
  output logic              is_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] C_AE    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_overflow;
  logic              r_underflow;
  logic [WIDTH-1:0]  w_rd_data;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_full;
  logic              w_empty;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A full FIFO still takes a push when a pop frees the slot on the same edge
  assign w_wr_ok = en_write & (~w_full | en_read);
  assign w_rd_ok = en_read & ~w_empty;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_ok),
    .wr_addr (r_wptr),
    .wr_data (data_in),
    .rd_addr (r_rptr),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_rd_ok) begin
        r_rptr     <= r_rptr + ADDR_W'(1);
        r_data_out <= w_rd_data;
      end

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase

      // A new error on the same edge as clr_err keeps the flag set
      if (en_write & w_full & ~en_read) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end

      if (en_read & w_empty) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign data_out     = r_data_out;
  assign count        = r_count;
  assign is_full      = w_full;
  assign is_empty     = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO: next generation of the 8-bit systolic-array data buffer.
- Generalised in width and depth.
- Adds:
  - occupancy count output;
  - programmable almost-full / almost-empty flags;
  - sticky overflow / underflow error flags with a clear input.
- Sits between producer PEs and consumers in the SA datapath; area-evaluated alongside existing buffers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of entries; power of two, >= 2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- ADDR_W, $clog2(DEPTH), derived; pointer width; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en_read  in  1  pop request.
- en_write  in  1  push request.
- data_in  in  WIDTH  push data.
- clr_err  in  1  synchronous clear of sticky error flags.
- data_out  out  WIDTH  registered pop data.
- is_full  out  1  count == DEPTH.
- is_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was ignored.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst=1:
  - pointers, count and data_out = 0;
  - is_empty = 1, almost_empty = 1;
  - is_full, almost_full, overflow, underflow = 0;
  - memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately; no clock is needed.
- Acceptance, evaluated on the flags before the edge:
  - wr_ok = en_write & (~is_full | en_read);
  - rd_ok = en_read & ~is_empty.
- Push: on wr_ok, mem[wptr] <= data_in and wptr increments, wrapping modulo DEPTH.
- Pop: on rd_ok, data_out <= mem[rptr] and rptr increments, wrapping.
  - Latency: data appears on data_out one edge after the pop request.
  - data_out holds its value when no pop is accepted.
- Count: count <= count + wr_ok - rd_ok.
- Flags: all flags are combinational from count; no flag depends directly on en_* inputs.
- Simultaneous pop+push:
  - when full: both accepted; count stays DEPTH; data_out gets the oldest entry; the new word is written into the freed slot.
  - when empty: push accepted, pop ignored, underflow set; data_out unchanged; no fall-through.
  - otherwise: both accepted; count unchanged.
- Error flags:
  - Overflow: en_write & is_full & ~en_read sets overflow; the data is dropped.
  - Underflow: en_read & is_empty sets underflow.
  - Error flags stay set until clr_err=1 at an edge.
  - If clr_err and a new error fall on the same edge, the set wins.
- Wrap-around: pointers are ADDR_W bits wide; full/empty are derived from count, never from pointer equality.
- No internal state machine; state is pointers, count and error bits.

Decomposition:
- Shared header (p2_defs): default p2_width and FIFO depth defines, reused by the bench and by other SA buffers.
- One sub-module: fifo_mem.
  - DEPTH x WIDTH register array.
  - Synchronous write port; combinational read address.
  - Allows swapping in a macro for area evaluation.
- sync_fifo_param holds the pointers, count, flags and data_out register.

Test Plan:
- Settings: WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless stated.
- 1. Reset then idle -> is_empty=1, almost_empty=1, count=0, data_out=0; asserting rst mid-stream with count=5 drops count to 0 without a clock edge.
- 2. Push 94, 87, -49; pop x3 -> data_out 94, 87, -49 on successive edges after each pop; count 3->0; almost_empty goes 0->1 when count reaches 2.
- 3. Push 1..8 -> is_full=1 at count 8, almost_full=1 from count 6; push 9 alone -> overflow=1, count stays 8; pop x8 -> data_out 1..8, proving 9 was dropped.
- 4. Full FIFO plus pop_push(9), then pop_push(10) -> count stays 8; data_out 1 then 2; drain gives 3..10; pointers wrap cleanly.
- 5. Empty FIFO plus pop_push(-36) -> underflow=1, count=1, data_out unchanged; next pop -> data_out=-36.
- 6. Overflow set; pulse clr_err -> overflow=0. Pulse clr_err on the same edge as a new empty pop -> underflow remains 1.
- 7. Re-run scenarios 2-4 with WIDTH=16, DEPTH=4 -> identical ordering and flag behaviour.
